// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and the memory controller.
// A hit replies the cycle after the request; a miss fetches one word, fills the line, then replies.
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        ins_asked,
    input  logic [31:0] ins_addr,
    output logic        ic_rdy,
    output logic [31:0] ins,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [31:0] mem_data
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        REPLY
    } state_t;

    state_t state, state_next;

    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];
    logic [29:0]           req_addr;

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_W-1:0]      fetch_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit;
    logic                  accept_hit;
    logic                  start_miss;
    logic                  fill;
    logic                  unused_addr_bits;

    assign fetch_idx        = ins_addr[INDEX_BITS+1:2];
    assign fetch_tag        = ins_addr[31:INDEX_BITS+2];
    assign fill_idx         = req_addr[INDEX_BITS-1:0];
    assign fill_tag         = req_addr[29:INDEX_BITS];
    assign hit              = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
    assign mem_addr         = {req_addr, 2'b00};
    assign unused_addr_bits = ^ins_addr[1:0];

    // With rdy low nothing is decoded, so every register below simply holds.
    always_comb begin
        state_next = state;
        accept_hit = 1'b0;
        start_miss = 1'b0;
        fill       = 1'b0;
        if (rdy) begin
            case (state)
                IDLE: begin
                    if (ins_asked) begin
                        if (hit) begin
                            accept_hit = 1'b1;
                        end else begin
                            start_miss = 1'b1;
                            state_next = MISS;
                        end
                    end
                end
                MISS: begin
                    if (mem_rdy) begin
                        fill       = 1'b1;
                        state_next = REPLY;
                    end
                end
                REPLY:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A miss reply forwards mem_data directly instead of re-reading the freshly filled line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= '0;
            ic_rdy   <= 1'b0;
            ins      <= 32'h0;
            mem_req  <= 1'b0;
            req_addr <= 30'h0;
        end else if (rdy) begin
            ic_rdy <= accept_hit | fill;
            if (accept_hit) begin
                ins <= data_mem[fetch_idx];
            end
            if (start_miss) begin
                mem_req  <= 1'b1;
                req_addr <= ins_addr[31:2];
            end
            if (fill) begin
                ins             <= mem_data;
                valid[fill_idx] <= 1'b1;
                mem_req         <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, stall, low address bits,
// back-to-back hits and reset during an outstanding miss.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        ins_asked;
    logic [31:0] ins_addr;
    logic        ic_rdy;
    logic [31:0] ins;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_data;

    int checks   = 0;
    int failures = 0;

    int          obs_pulses;
    logic        obs_saw_req;
    logic [31:0] obs_req_addr;
    logic [31:0] obs_ins;
    int          obs_latency;

    always #5 clk = ~clk;

    icache #(.INDEX_BITS(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .ins_asked (ins_asked),
        .ins_addr  (ins_addr),
        .ic_rdy    (ic_rdy),
        .ins       (ins),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdy   (mem_rdy),
        .mem_data  (mem_data)
    );

    // Issues one fetch and plays the memory controller, answering delay cycles after
    // mem_req is first seen; records what the cache did over a fixed window.
    task automatic apply_fetch(input logic [31:0] addr, input logic [31:0] data, input int delay);
        int req_cycles;
        req_cycles   = 0;
        obs_pulses   = 0;
        obs_saw_req  = 1'b0;
        obs_req_addr = 32'hFFFF_FFFF;
        obs_ins      = 32'hDEAD_BEEF;
        obs_latency  = 0;
        @(negedge clk);
        ins_asked = 1'b1;
        ins_addr  = addr;
        for (int c = 1; c <= delay + 6; c++) begin
            @(negedge clk);
            ins_asked = 1'b0;
            mem_rdy   = 1'b0;
            if (ic_rdy) begin
                obs_pulses++;
                obs_ins = ins;
                if (obs_latency == 0) obs_latency = c;
            end
            if (mem_req) begin
                obs_saw_req  = 1'b1;
                obs_req_addr = mem_addr;
                req_cycles++;
                if (req_cycles == delay) begin
                    mem_rdy  = 1'b1;
                    mem_data = data;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rdy       = 1'b1;
        ins_asked = 1'b0;
        ins_addr  = 32'h0;
        mem_rdy   = 1'b0;
        mem_data  = 32'h0;
        #1;
        checks++;
        if (ic_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_ic_rdy: got %b expected 0", ic_rdy); end
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++;
        if (ins !== 32'h0) begin failures++; $display("[TB] FAIL reset_ins: got %h expected 00000000", ins); end
        checks++;
        if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_addr: got %h expected 00000000", mem_addr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        apply_fetch(32'h0, 32'h0000_0013, 3);
        checks++;
        if (obs_saw_req !== 1'b1) begin failures++; $display("[TB] FAIL cold_miss_req: got %b expected 1", obs_saw_req); end
        checks++;
        if (obs_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL cold_miss_addr: got %h expected 00000000", obs_req_addr); end
        checks++;
        if (obs_pulses != 1) begin failures++; $display("[TB] FAIL cold_miss_pulses: got %0d expected 1", obs_pulses); end
        checks++;
        if (obs_ins !== 32'h0000_0013) begin failures++; $display("[TB] FAIL cold_miss_ins: got %h expected 00000013", obs_ins); end
        checks++;
        if (obs_latency != 4) begin failures++; $display("[TB] FAIL cold_miss_latency: got %0d expected 4", obs_latency); end
    endtask

    task automatic test_hit();
        apply_fetch(32'h0, 32'hBAD0_BAD0, 3);
        checks++;
        if (obs_saw_req !== 1'b0) begin failures++; $display("[TB] FAIL hit_no_req: got %b expected 0", obs_saw_req); end
        checks++;
        if (obs_latency != 1) begin failures++; $display("[TB] FAIL hit_latency: got %0d expected 1", obs_latency); end
        checks++;
        if (obs_pulses != 1) begin failures++; $display("[TB] FAIL hit_pulses: got %0d expected 1", obs_pulses); end
        checks++;
        if (obs_ins !== 32'h0000_0013) begin failures++; $display("[TB] FAIL hit_ins: got %h expected 00000013", obs_ins); end
    endtask

    task automatic test_conflict();
        apply_fetch(32'h100, 32'h0FF0_0113, 2);
        checks++;
        if (obs_saw_req !== 1'b1) begin failures++; $display("[TB] FAIL conflict_miss_req: got %b expected 1", obs_saw_req); end
        checks++;
        if (obs_req_addr !== 32'h100) begin failures++; $display("[TB] FAIL conflict_addr: got %h expected 00000100", obs_req_addr); end
        checks++;
        if (obs_ins !== 32'h0FF0_0113) begin failures++; $display("[TB] FAIL conflict_ins: got %h expected 0ff00113", obs_ins); end
        apply_fetch(32'h0, 32'h0000_0013, 1);
        checks++;
        if (obs_saw_req !== 1'b1) begin failures++; $display("[TB] FAIL conflict_refetch_req: got %b expected 1", obs_saw_req); end
        checks++;
        if (obs_ins !== 32'h0000_0013) begin failures++; $display("[TB] FAIL conflict_refetch_ins: got %h expected 00000013", obs_ins); end
        checks++;
        if (obs_latency != 2) begin failures++; $display("[TB] FAIL conflict_refetch_latency: got %0d expected 2", obs_latency); end
    endtask

    task automatic test_stall();
        int stall_pulses;
        int pulses;
        int first_at;
        logic [31:0] seen_ins;
        stall_pulses = 0;
        pulses       = 0;
        first_at     = 0;
        seen_ins     = 32'hDEAD_BEEF;
        @(negedge clk);
        ins_asked = 1'b1;
        ins_addr  = 32'h8;
        @(negedge clk);
        ins_asked = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            failures++;
            $display("[TB] FAIL stall_req: got req=%b addr=%h expected req=1 addr=00000008", mem_req, mem_addr);
        end
        rdy      = 1'b0;
        mem_rdy  = 1'b1;
        mem_data = 32'h00A0_0193;
        repeat (4) begin
            @(negedge clk);
            if (ic_rdy) stall_pulses++;
        end
        checks++;
        if (stall_pulses != 0) begin failures++; $display("[TB] FAIL stall_no_reply: got %0d pulses expected 0", stall_pulses); end
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL stall_req_held: got %b expected 1", mem_req); end
        rdy = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            mem_rdy = 1'b0;
            if (ic_rdy) begin
                pulses++;
                seen_ins = ins;
                if (first_at == 0) first_at = c;
            end
        end
        checks++;
        if (pulses != 1) begin failures++; $display("[TB] FAIL stall_pulses: got %0d expected 1", pulses); end
        checks++;
        if (first_at != 1) begin failures++; $display("[TB] FAIL stall_reply_cycle: got %0d expected 1", first_at); end
        checks++;
        if (seen_ins !== 32'h00A0_0193) begin failures++; $display("[TB] FAIL stall_ins: got %h expected 00a00193", seen_ins); end
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_req_drop: got %b expected 0", mem_req); end
    endtask

    task automatic test_low_bits();
        apply_fetch(32'h4, 32'h0040_0093, 2);
        checks++;
        if (obs_req_addr !== 32'h4) begin failures++; $display("[TB] FAIL low_bits_fill_addr: got %h expected 00000004", obs_req_addr); end
        apply_fetch(32'h6, 32'hBAD0_BAD0, 2);
        checks++;
        if (obs_saw_req !== 1'b0) begin failures++; $display("[TB] FAIL low_bits_hit: got req=%b expected 0", obs_saw_req); end
        checks++;
        if (obs_ins !== 32'h0040_0093) begin failures++; $display("[TB] FAIL low_bits_ins: got %h expected 00400093", obs_ins); end
        checks++;
        if (mem_addr !== 32'h4) begin failures++; $display("[TB] FAIL low_bits_mem_addr: got %h expected 00000004", mem_addr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [31:0] words [4];
        addrs = '{32'h0, 32'h4, 32'h8, 32'h0};
        words = '{32'h0000_0013, 32'h0040_0093, 32'h00A0_0193, 32'h0000_0013};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ins_asked = 1'b1;
            ins_addr  = addrs[i];
            @(negedge clk);
            ins_asked = 1'b0;
            checks++;
            if (ic_rdy !== 1'b1 || ins !== words[i] || mem_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_hit_%0d: got rdy=%b ins=%h req=%b expected rdy=1 ins=%h req=0",
                         i, ic_rdy, ins, mem_req, words[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (ic_rdy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_pulse_end: got %b expected 0", ic_rdy); end
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk);
        ins_asked = 1'b1;
        ins_addr  = 32'h40;
        @(negedge clk);
        ins_asked = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL mid_miss_req: got %b expected 1", mem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL mid_miss_async_req: got %b expected 0", mem_req); end
        checks++;
        if (ic_rdy !== 1'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL mid_miss_async_out: got rdy=%b addr=%h expected rdy=0 addr=00000000", ic_rdy, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply_fetch(32'h0, 32'h0000_0013, 2);
        checks++;
        if (obs_saw_req !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_miss: got req=%b expected 1", obs_saw_req); end
        checks++;
        if (obs_ins !== 32'h0000_0013 || obs_pulses != 1) begin
            failures++;
            $display("[TB] FAIL post_reset_reply: got ins=%h pulses=%0d expected ins=00000013 pulses=1", obs_ins, obs_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_stall();
        test_low_bits();
        test_back_to_back();
        test_reset_mid_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
